imem_port_arbiter: RTL and testbench

//  Shares the single port of the 1024x64 instruction/vector memory block RAM
//  (clka, wea, addra, dina, douta) between NUM_REQ requesters (fetch unit,

---
 rtl/imem_port_arbiter_pkg.sv | 20 ++
 rtl/imem_port_arbiter_if.sv | 39 +++
 rtl/imem_port_arbiter_rr_arbiter.sv | 36 +++
 rtl/imem_port_arbiter.sv | 109 ++++++++++
 tb/tb_imem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/vector memory port arbiter.
// Replaces the old imem_defs.vh header: RAM geometry, default widths, tag layout.
package imem_port_arbiter_pkg;

    localparam int unsigned RAM_DEPTH  = 1024;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned RID_W      = 3;

    typedef enum logic [0:0] {
        StUnlocked,
        StLocked
    } lock_state_e;

    typedef struct packed {
        logic             valid;
        logic [RID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Requester-side and RAM-side signals of the shared block RAM port.
// The arbiter uses 'slave', requesters use 'master', the RAM uses 'mem'.
interface imem_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = imem_port_arbiter_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W  = imem_port_arbiter_pkg::DEF_DATA_W
);
    import imem_port_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rvalid;
    logic [RID_W-1:0]          rid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_wea;
    logic [ADDR_W-1:0]         mem_addra;
    logic [DATA_W-1:0]         mem_dina;
    logic [DATA_W-1:0]         mem_douta;

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata,
        input  gnt, rvalid, rid, rdata
    );

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata, mem_douta,
        output gnt, rvalid, rid, rdata, mem_wea, mem_addra, mem_dina
    );

    modport mem (
        input  mem_wea, mem_addra, mem_dina,
        output mem_douta
    );

endinterface

// File: rtl/imem_port_arbiter_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping.
// Eligible means requesting and not masked off by an active lock.
module imem_port_arbiter_rr_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [RID_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [RID_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic               found;

    assign cand = req & mask;

    // Outer loop walks priority distance from ptr, so the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && cand[i] && (((i + NUM_REQ - 32'(ptr)) % NUM_REQ) == k)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = RID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single block RAM port among NUM_REQ requesters with round-robin
// grant, optional burst lock and id-tagged read return after READ_LAT clocks.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned READ_LAT = 1
) (
    input logic                clka,
    input logic                rst_n,
    imem_port_arbiter_if.slave bus
);

    lock_state_e        state_q, state_d;
    logic [RID_W-1:0]   owner_q, owner_d;
    logic [RID_W-1:0]   ptr_q, ptr_d;
    logic [RID_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] mask, arb_gnt;
    logic               transfer, win_we, win_lock;
    rd_tag_t            tag_in;
    rd_tag_t            tag_q [READ_LAT];

    assign mask = (state_q == StLocked) ? (NUM_REQ'(1) << owner_q) : '1;

    imem_port_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req  (bus.req),
        .mask (mask),
        .ptr  (ptr_q),
        .gnt  (arb_gnt),
        .idx  (win_idx)
    );

    // Grant is forced off while reset is held, independent of the clock.
    assign bus.gnt  = rst_n ? arb_gnt : '0;
    assign transfer = |bus.gnt;

    always_comb begin
        win_we        = 1'b0;
        win_lock      = 1'b0;
        bus.mem_addra = '0;
        bus.mem_dina  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.gnt[i]) begin
                win_we        = bus.req_we[i];
                win_lock      = bus.req_lock[i];
                bus.mem_addra = bus.req_addr[i*ADDR_W +: ADDR_W];
                bus.mem_dina  = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
        bus.mem_wea = win_we;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            StUnlocked: begin
                if (transfer && win_lock) begin
                    state_d = StLocked;
                    owner_d = win_idx;
                end
            end
            StLocked: begin
                // Only the owner can be granted here, so any unlocked transfer ends the burst.
                if (transfer && !win_lock) begin
                    state_d = StUnlocked;
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (win_idx == RID_W'(NUM_REQ - 1)) ? '0 : win_idx + RID_W'(1);
        end
        tag_in.valid = transfer & ~win_we;
        tag_in.id    = win_idx;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StUnlocked;
            owner_q <= '0;
            ptr_q   <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            tag_q[0] <= tag_in;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign bus.rvalid = tag_q[READ_LAT-1].valid;
    assign bus.rid    = tag_q[READ_LAT-1].id;
    assign bus.rdata  = bus.mem_douta;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench: arbiter in front of a write-first RAM, directed scenarios followed by
// random traffic, all compared each cycle against a behavioural reference.
module tb_imem_port_arbiter;
    import imem_port_arbiter_pkg::*;

    localparam int unsigned N   = 2;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 64;
    localparam int unsigned LAT = 1;
    localparam int unsigned AWT = N * AW;
    localparam int unsigned DWT = N * DW;
    localparam int HALF_PERIOD  = 50;

    typedef struct {
        int unsigned   due;
        int            id;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic    clka = 1'b0;
    logic    rst_n;
    int      checks = 0;
    int      errors = 0;
    rd_exp_t pend[$];
    logic [DW-1:0] ram    [1024];
    logic [DW-1:0] shadow [1024];

    imem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_port_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .READ_LAT (LAT)
    ) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #(HALF_PERIOD) clka = ~clka;

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return {32'hC0E0_0000 | a, ~a};
    endfunction

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [AW-1:0] field_addr(input int i);
        logic [AWT-1:0] t;
        t = bus.req_addr >> (i * AW);
        return t[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] field_data(input int i);
        logic [DWT-1:0] t;
        t = bus.req_wdata >> (i * DW);
        return t[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic drive(input int i, input bit r, input bit we, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [N-1:0] m;
        m             = N'(1) << i;
        bus.req       = r  ? (bus.req | m)      : (bus.req & ~m);
        bus.req_we    = we ? (bus.req_we | m)   : (bus.req_we & ~m);
        bus.req_lock  = lk ? (bus.req_lock | m) : (bus.req_lock & ~m);
        bus.req_addr  = (bus.req_addr & ~(AWT'({AW{1'b1}}) << (i * AW))) | (AWT'(a) << (i * AW));
        bus.req_wdata = (bus.req_wdata & ~(DWT'({DW{1'b1}}) << (i * DW))) | (DWT'(d) << (i * DW));
    endtask

    task automatic idle();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic smp();
        @(negedge clka);
    endtask

    // Write-first single-port RAM with one clock of read latency.
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clka);
            if (bus.mem_wea) begin
                ram[bus.mem_addra] = bus.mem_dina;
                bus.mem_douta      = bus.mem_dina;
            end else begin
                bus.mem_douta = ram[bus.mem_addra];
            end
        end
    end

    // Reference: decide the winner from the arbitration rules, check every
    // output at mid-cycle, and commit the access only if the clock edge lands.
    initial begin
        int unsigned   cyc;
        int            m_ptr, m_owner, win, c;
        bit            m_locked, exp_rv, we, lk;
        logic [N-1:0]  exp_gnt;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rd_exp_t       e;
        cyc = 0; m_ptr = 0; m_owner = 0; m_locked = 0;
        we = 0; lk = 0; a = '0; d = '0;
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
        forever begin
            @(negedge clka);
            cyc++;
            win = -1;
            if (!rst_n) begin
                chk("rst_gnt", bus.gnt, 0);
                chk("rst_wea", bus.mem_wea, 0);
                chk("rst_addra", bus.mem_addra, 0);
                chk("rst_rvalid", bus.rvalid, 0);
                chk("rst_rid", bus.rid, 0);
                m_ptr = 0; m_locked = 0; m_owner = 0;
                pend.delete();
            end else begin
                exp_rv = 0;
                e      = '{due: 0, id: 0, data: '0};
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e      = pend.pop_front();
                    exp_rv = 1;
                end
                chk("rvalid", bus.rvalid, exp_rv);
                if (exp_rv) begin
                    chk("rid", bus.rid, e.id);
                    chk("rdata", bus.rdata, e.data);
                end
                if (m_locked) begin
                    if (bit_of(bus.req, m_owner)) win = m_owner;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        c = (m_ptr + k) % N;
                        if (win < 0 && bit_of(bus.req, c)) win = c;
                    end
                end
                exp_gnt = (win >= 0) ? (N'(1) << win) : '0;
                chk("gnt", bus.gnt, exp_gnt);
                if (win >= 0) begin
                    a  = field_addr(win);
                    d  = field_data(win);
                    we = bit_of(bus.req_we, win);
                    lk = bit_of(bus.req_lock, win);
                    chk("wea", bus.mem_wea, we);
                    chk("addra", bus.mem_addra, a);
                    chk("dina", bus.mem_dina, d);
                end else begin
                    chk("idle_wea", bus.mem_wea, 0);
                    chk("idle_addra", bus.mem_addra, 0);
                    chk("idle_dina", bus.mem_dina, 0);
                end
            end
            @(posedge clka);
            if (rst_n && win >= 0) begin
                if (we) shadow[a] = d;
                else pend.push_back('{due: cyc + LAT, id: win, data: shadow[a]});
                m_ptr    = (win + 1) % N;
                m_locked = lk;
                m_owner  = win;
            end
        end
    end

    initial begin
        logic [N-1:0] g;
        int           cnt;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clka);
        smp();
        chk("init_gnt", bus.gnt, 0);
        chk("init_rvalid", bus.rvalid, 0);
        step();
        rst_n = 1'b1;

        // Single requester streams reads 0..7 from the preloaded contents.
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 0, AW'(k), '0);
            smp();
            chk("t6_gnt", bus.gnt, 2'b01);
            if (k > 0) begin
                chk("t6_rdata", bus.rdata, init_word(k - 1));
                if (bus.rvalid) cnt++;
            end
            step();
        end
        idle();
        smp();
        chk("t6_rdata_last", bus.rdata, init_word(7));
        if (bus.rvalid) cnt++;
        chk("t6_count", cnt, 8);
        step();

        // Write then read-back of the same address by another requester.
        drive(0, 1, 1, 0, 10'd5, 64'hDEAD_BEEF);
        smp();
        chk("t2_wr_gnt", bus.gnt, 2'b01);
        chk("t2_wr_wea", bus.mem_wea, 1);
        step();
        idle();
        drive(1, 1, 0, 0, 10'd5, '0);
        smp();
        chk("t2_rd_gnt", bus.gnt, 2'b10);
        step();
        idle();
        smp();
        chk("t2_rvalid", bus.rvalid, 1);
        chk("t2_rid", bus.rid, 1);
        chk("t2_rdata", bus.rdata, 64'hDEAD_BEEF);
        step();

        // Both requesting reads continuously: strict alternation.
        drive(0, 1, 0, 0, 10'd10, '0);
        drive(1, 1, 0, 0, 10'd11, '0);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t3_gnt", bus.gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("t3_rid", bus.rid, (k - 1) % 2);
            step();
        end
        idle();
        smp();
        chk("t3_rid_last", bus.rid, 1);
        step();

        // Locked burst by requester 0 starves requester 1, even while 0 idles.
        drive(1, 1, 0, 0, 10'd20, '0);
        drive(0, 1, 0, 1, 10'd1, '0);
        smp(); chk("t4_gnt_a", bus.gnt, 2'b01); step();
        drive(0, 0, 0, 0, 10'd0, '0);
        smp(); chk("t4_stall", bus.gnt, 2'b00); step();
        drive(0, 1, 0, 1, 10'd2, '0);
        smp(); chk("t4_gnt_b", bus.gnt, 2'b01); step();
        drive(0, 1, 0, 0, 10'd3, '0);
        smp(); chk("t4_gnt_c", bus.gnt, 2'b01); step();
        drive(0, 1, 0, 0, 10'd4, '0);
        smp(); chk("t4_gnt_req1", bus.gnt, 2'b10); step();
        idle();

        // Asynchronous reset mid-cycle kills a pending write immediately.
        drive(0, 1, 1, 0, 10'd900, 64'h1234);
        smp();
        chk("t1_pre_wea", bus.mem_wea, 1);
        #10 rst_n = 1'b0;
        #1;
        chk("t1_gnt", bus.gnt, 0);
        chk("t1_wea", bus.mem_wea, 0);
        chk("t1_rvalid", bus.rvalid, 0);
        step();
        idle();
        smp();
        step();
        rst_n = 1'b1;

        // In-flight read is dropped by reset; first grant afterwards goes to 0.
        drive(0, 1, 0, 0, 10'd6, '0);
        smp(); step();
        drive(0, 1, 0, 0, 10'd7, '0);
        smp();
        chk("t5_gnt", bus.gnt, 2'b01);
        #10 rst_n = 1'b0;
        step();
        chk("t5_rvalid_edge", bus.rvalid, 0);
        smp();
        step();
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 10'd8, '0);
        drive(1, 1, 0, 0, 10'd9, '0);
        smp();
        chk("t5_first_gnt", bus.gnt, 2'b01);
        chk("t5_no_rvalid", bus.rvalid, 0);
        step();
        idle();

        // Random traffic; a waiting requester keeps its fields stable.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            smp();
            g = bus.gnt;
            step();
            rst_n = (cyc % 400 == 200) ? 1'b0 : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!(bit_of(bus.req, i) && !bit_of(g, i))) begin
                    drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 5) == 0, AW'($urandom_range(0, 15)),
                          {$urandom, $urandom});
                end
            end
        end
        idle();
        rst_n = 1'b1;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
